// File: rtl/io_channel_bank.sv
// io_channel_bank: handshaked input/output channel registers with status, interrupt mask and irq behind a core register port
module io_channel_bank #(
   parameter int WIDTH = 15,
   parameter int N_IN  = 5,
   parameter int N_OUT = 4,
   parameter int SEL_W = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [SEL_W-1:0]       sel_read,
   input  logic                   en_read,
   output logic [WIDTH-1:0]       data_read,
   input  logic [SEL_W-1:0]       sel_write,
   input  logic                   en_write,
   input  logic [WIDTH-1:0]       data_write,
   input  logic [N_IN*WIDTH-1:0]  in_data,
   input  logic [N_IN-1:0]        in_valid,
   output logic [N_IN-1:0]        in_ready,
   output logic [N_OUT*WIDTH-1:0] out_data,
   output logic [N_OUT-1:0]       out_valid,
   input  logic [N_OUT-1:0]       out_ready,
   output logic                   irq
);
   localparam logic [SEL_W-1:0] STATUS_A = SEL_W'((2 ** SEL_W) - 2);
   localparam logic [SEL_W-1:0] MASK_A   = SEL_W'((2 ** SEL_W) - 1);
   logic [N_IN-1:0][WIDTH-1:0]  hold, hold_n;
   logic [N_OUT-1:0][WIDTH-1:0] obuf, obuf_n;
   logic [N_IN-1:0]             full, full_n, cap, rd_in;
   logic [N_OUT-1:0]            wr_out, acc, drop_ev, ov_n;
   logic [WIDTH-1:0]            mask, mask_n, status, rd_val;
   logic                        drop, drop_n, irq_n, wr_status, wr_mask;
   assign in_ready  = ~full & {N_IN{~reset}};
   assign out_data  = obuf;
   assign wr_status = en_write & (sel_write == STATUS_A);
   assign wr_mask   = en_write & (sel_write == MASK_A);
   assign cap       = in_valid & in_ready;
   assign full_n    = cap | (full & ~rd_in);
   for (genvar i = 0; i < N_IN; i++) begin : g_in
      assign rd_in[i]  = en_read & (sel_read == SEL_W'(i));
      assign hold_n[i] = cap[i] ? in_data[i*WIDTH +: WIDTH] : hold[i];
   end
   // a write may replace a pending word only when that word is leaving this same cycle
   assign acc     = wr_out & (~out_valid | out_ready);
   assign drop_ev = wr_out & out_valid & ~out_ready;
   assign ov_n    = acc | (out_valid & ~out_ready);
   for (genvar i = 0; i < N_OUT; i++) begin : g_out
      assign wr_out[i] = en_write & (sel_write == SEL_W'(N_IN + i));
      assign obuf_n[i] = acc[i] ? data_write : obuf[i];
   end
   assign drop_n = (|drop_ev) | (drop & ~(wr_status & data_write[WIDTH-1]));
   assign mask_n = wr_mask ? data_write : mask;
   assign irq_n  = (|(full_n & mask_n[N_IN-1:0])) | (drop_n & mask_n[WIDTH-1]);
   always_comb begin
      status = '0;
      status[N_IN-1:0] = full;
      status[N_IN+N_OUT-1:N_IN] = out_valid;
      status[WIDTH-1] = drop;
      rd_val = sel_read == STATUS_A ? status : sel_read == MASK_A ? mask : '0;
      for (int k = 0; k < N_IN; k++)
         rd_val = sel_read == SEL_W'(k) ? hold[k] : rd_val;
      for (int k = 0; k < N_OUT; k++)
         rd_val = sel_read == SEL_W'(N_IN + k) ? obuf[k] : rd_val;
   end
   always_ff @(posedge clock)
      if (reset) begin
         hold      <= '0;
         obuf      <= '0;
         full      <= '0;
         out_valid <= '0;
         drop      <= 1'b0;
         mask      <= '0;
         data_read <= '0;
         irq       <= 1'b0;
      end else begin
         hold      <= hold_n;
         obuf      <= obuf_n;
         full      <= full_n;
         out_valid <= ov_n;
         drop      <= drop_n;
         mask      <= mask_n;
         data_read <= en_read ? rd_val : data_read;
         irq       <= irq_n;
      end
endmodule

// File: tb/tb_io_channel_bank.sv
// tb_io_channel_bank: scoreboard bench for io_channel_bank against a per-cycle reference model
module tb_io_channel_bank;
   localparam int WIDTH = 15, N_IN = 5, N_OUT = 4, SEL_W = 4;
   localparam int ST_A = 2 ** SEL_W - 2, MK_A = 2 ** SEL_W - 1;
   logic                   clock = 1'b0;
   logic                   reset;
   logic [SEL_W-1:0]       sel_read, sel_write;
   logic                   en_read, en_write, irq;
   logic [WIDTH-1:0]       data_read, data_write;
   logic [N_IN*WIDTH-1:0]  in_data;
   logic [N_IN-1:0]        in_valid, in_ready;
   logic [N_OUT*WIDTH-1:0] out_data;
   logic [N_OUT-1:0]       out_valid, out_ready;
   int n_tests = 0, n_fail = 0;
   logic [WIDTH-1:0] m_hold [N_IN];
   logic [WIDTH-1:0] m_obuf [N_OUT];
   logic [N_IN-1:0]  m_full;
   logic [N_OUT-1:0] m_pend;
   logic [WIDTH-1:0] m_mask;
   logic             m_drop, m_irq;
   logic [WIDTH-1:0] rd_q [$];
   logic [WIDTH-1:0] out_q [N_OUT][$];
   bit mon_on = 1'b0;
   io_channel_bank #(.WIDTH(WIDTH), .N_IN(N_IN), .N_OUT(N_OUT), .SEL_W(SEL_W)) dut (
      .clock(clock), .reset(reset), .sel_read(sel_read), .en_read(en_read), .data_read(data_read),
      .sel_write(sel_write), .en_write(en_write), .data_write(data_write), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .irq(irq)
   );
   always #5 clock = ~clock;
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic fail_now(string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard had no expected entry", nm);
   endtask
   function automatic logic [WIDTH-1:0] model_read(int a);
      if (a < N_IN) return m_hold[a];
      if (a < N_IN + N_OUT) return m_obuf[a - N_IN];
      if (a == ST_A) return WIDTH'(m_full) | (WIDTH'(m_pend) << N_IN) | (WIDTH'(m_drop) << (WIDTH - 1));
      if (a == MK_A) return m_mask;
      return '0;
   endfunction
   task automatic model_reset();
      foreach (m_hold[k]) m_hold[k] = '0;
      foreach (m_obuf[k]) begin
         m_obuf[k] = '0;
         out_q[k].delete();
      end
      m_full = '0;
      m_pend = '0;
      m_mask = '0;
      m_drop = 1'b0;
      m_irq  = 1'b0;
   endtask
   // compute the effect of the current inputs, advance one edge, then commit the model
   task automatic drive();
      logic [WIDTH-1:0] n_hold [N_IN];
      logic [WIDTH-1:0] n_obuf [N_OUT];
      logic [N_IN-1:0]  n_full = m_full;
      logic [N_OUT-1:0] n_pend = m_pend;
      logic [WIDTH-1:0] n_mask = m_mask;
      logic             n_drop = m_drop;
      logic             n_irq = m_irq;
      int rs = int'(sel_read), ws = int'(sel_write);
      n_hold = m_hold;
      n_obuf = m_obuf;
      if (!reset) begin
         if (en_read) rd_q.push_back(model_read(rs));
         for (int k = 0; k < N_IN; k++) begin
            if (en_read && rs == k) n_full[k] = 1'b0;
            if (in_valid[k] && !m_full[k]) begin
               n_hold[k] = in_data[k*WIDTH +: WIDTH];
               n_full[k] = 1'b1;
            end
         end
         if (en_write && ws == ST_A && data_write[WIDTH-1]) n_drop = 1'b0;
         if (en_write && ws == MK_A) n_mask = data_write;
         for (int j = 0; j < N_OUT; j++) begin
            if (m_pend[j] && out_ready[j]) n_pend[j] = 1'b0;
            if (en_write && ws == N_IN + j) begin
               if (!m_pend[j] || out_ready[j]) begin
                  n_obuf[j] = data_write;
                  n_pend[j] = 1'b1;
                  out_q[j].push_back(data_write);
               end else n_drop = 1'b1;
            end
         end
         n_irq = (|(n_full & n_mask[N_IN-1:0])) || (n_drop && n_mask[WIDTH-1]);
      end
      @(posedge clock);
      if (reset) model_reset();
      else begin
         m_hold = n_hold;
         m_obuf = n_obuf;
         m_full = n_full;
         m_pend = n_pend;
         m_mask = n_mask;
         m_drop = n_drop;
         m_irq  = n_irq;
      end
      #2;
   endtask
   task automatic idle();
      en_read = 1'b0;
      en_write = 1'b0;
      sel_read = '0;
      sel_write = '0;
      data_write = '0;
      in_valid = '0;
      out_ready = '0;
   endtask
   task automatic rd(int a);
      idle();
      en_read = 1'b1;
      sel_read = SEL_W'(a);
      drive();
   endtask
   task automatic wr(int a, logic [WIDTH-1:0] v);
      idle();
      en_write = 1'b1;
      sel_write = SEL_W'(a);
      data_write = v;
      drive();
   endtask
   initial begin
      bit rd_pend = 1'b0;
      logic [N_IN-1:0] er;
      wait (mon_on);
      forever begin
         @(negedge clock);
         if (rd_pend) begin
            if (rd_q.size() == 0) fail_now("rd_q");
            else chk("data_read", data_read, rd_q.pop_front());
         end
         rd_pend = en_read && !reset;
         for (int j = 0; j < N_OUT; j++) begin
            if (!reset && out_valid[j] && out_ready[j]) begin
               if (out_q[j].size() == 0) fail_now("out_q");
               else chk("out_word", out_data[j*WIDTH +: WIDTH], out_q[j].pop_front());
            end
            chk("out_data", out_data[j*WIDTH +: WIDTH], m_obuf[j]);
         end
         er = reset ? '0 : ~m_full;
         chk("in_ready", in_ready, er);
         chk("out_valid", out_valid, m_pend);
         chk("irq", irq, m_irq);
      end
   end
   initial begin
      model_reset();
      idle();
      reset = 1'b1;
      in_valid = '1;
      for (int k = 0; k < N_IN; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      drive();
      mon_on = 1'b1;
      drive();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_data_read", data_read, 0);
      chk("rst_irq", irq, 0);
      chk("rst_out_valid", out_valid, 0);
      reset = 1'b0;
      idle();
      drive();
      chk("rel_in_ready", in_ready, 5'h1f);
      idle();
      in_valid[2] = 1'b1;
      in_data[2*WIDTH +: WIDTH] = 15'h1234;
      drive();
      chk("cap_in_ready2", in_ready[2], 0);
      rd(ST_A);
      chk("status_full2", data_read, 15'h0004);
      rd(2);
      chk("read_ch2", data_read, 15'h1234);
      chk("freed_ch2", in_ready[2], 1);
      idle();
      en_read = 1'b1;
      sel_read = 0;
      in_valid[0] = 1'b1;
      in_data[0 +: WIDTH] = 15'h7FFF;
      drive();
      chk("simul_old", data_read, 0);
      chk("simul_full0", in_ready[0], 0);
      rd(0);
      chk("simul_new", data_read, 15'h7FFF);
      wr(N_IN, 15'h0AAA);
      wr(N_IN, 15'h0555);
      chk("bp_out_data", out_data[0 +: WIDTH], 15'h0AAA);
      rd(ST_A);
      chk("bp_status", data_read, 15'h4020);
      idle();
      out_ready[0] = 1'b1;
      drive();
      chk("bp_drained", out_valid[0], 0);
      wr(ST_A, 15'h4000);
      rd(ST_A);
      chk("drop_clear", data_read, 0);
      wr(MK_A, 15'h0002);
      chk("mask_irq0", irq, 0);
      idle();
      in_valid[1] = 1'b1;
      drive();
      chk("irq_set", irq, 1);
      rd(1);
      chk("irq_clr", irq, 0);
      idle();
      in_valid[0] = 1'b1;
      drive();
      chk("irq_masked", irq, 0);
      rd(ST_A - 1);
      chk("unmapped_rd", data_read, 0);
      wr(ST_A - 1, 15'h7FFF);
      wr(3, 15'h7FFF);
      rd(MK_A);
      chk("mask_rd", data_read, 15'h0002);
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         en_read = 1'($urandom);
         sel_read = SEL_W'($urandom);
         en_write = 1'($urandom);
         sel_write = SEL_W'($urandom);
         data_write = WIDTH'($urandom);
         in_valid = N_IN'($urandom);
         for (int k = 0; k < N_IN; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
         out_ready = N_OUT'($urandom);
         drive();
      end
      reset = 1'b0;
      idle();
      drive();
      drive();
      @(negedge clock);
      #1;
      if (rd_q.size() != 0) fail_now("rd_q_left");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
